// File: rtl/cache_def.sv
// -----------------------------------------------------------------------------
// cache_def
// Shared L1 data-cache definitions. This extension adds what the memory-side
// line adapter needs: its state encoding and the line geometry constants.
//   LINE_WORDS        : 32-bit words per cache line
//   LINE_OFFSET_BITS  : byte-offset bits inside a line
//   cache_data_type   : one full 128-bit cache line
//   line_adapter_state_type : adapter FSM states
// -----------------------------------------------------------------------------
package cache_def;

  localparam int LINE_WORDS       = 4;
  localparam int LINE_OFFSET_BITS = 4;

  typedef logic [127:0] cache_data_type;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    RESP
  } line_adapter_state_type;

endpackage

// File: rtl/line_word_buffer.sv
// -----------------------------------------------------------------------------
// line_word_buffer
// Small register file holding one cache line as WORDS words. Serves as the
// source of writeback words and as the assembly area for fill words.
// Ports:
//   clk          : clock
//   load_i       : load the whole line from load_line_i (wins over wr_en_i)
//   load_line_i  : full line to load
//   wr_en_i      : write one word
//   wr_idx_i     : index of the word written
//   wr_data_i    : word written
//   rd_idx_i     : index of the word read
//   rd_data_o    : word at rd_idx_i (combinational read)
//   line_o       : all words in parallel, word i at [WORD_WIDTH*i +: WORD_WIDTH]
// -----------------------------------------------------------------------------
module line_word_buffer
  import cache_def::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int WORDS      = LINE_WORDS,
  localparam int IDX_W     = $clog2(WORDS)
) (
  input  logic                        clk,
  input  logic                        load_i,
  input  logic [WORD_WIDTH*WORDS-1:0] load_line_i,
  input  logic                        wr_en_i,
  input  logic [IDX_W-1:0]            wr_idx_i,
  input  logic [WORD_WIDTH-1:0]       wr_data_i,
  input  logic [IDX_W-1:0]            rd_idx_i,
  output logic [WORD_WIDTH-1:0]       rd_data_o,
  output logic [WORD_WIDTH*WORDS-1:0] line_o
);

  logic [WORD_WIDTH-1:0] words_q [WORDS];

  // Pure data storage: no reset, contents are always written before use.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WORDS; i++) begin
      if (load_i) begin
        words_q[i] <= load_line_i[i*WORD_WIDTH +: WORD_WIDTH];
      end else if (wr_en_i && (wr_idx_i == IDX_W'(i))) begin
        words_q[i] <= wr_data_i;
      end
    end
  end

  assign rd_data_o = words_q[rd_idx_i];

  always_comb begin
    line_o = '0;
    for (int i = 0; i < WORDS; i++) begin
      line_o[i*WORD_WIDTH +: WORD_WIDTH] = words_q[i];
    end
  end

endmodule

// File: rtl/dcache_line_adapter.sv
// -----------------------------------------------------------------------------
// dcache_line_adapter
// Memory-side stage below the L1 data cache controller. Takes one line request
// (fill or writeback), serializes it into WORDS_PER_LINE word transactions on
// the RAM word port and, for fills, returns the reassembled line as a
// one-cycle response. Writebacks also end with a one-cycle completion pulse.
//
// Optional feature (macro DCACHE_CRITICAL_WORD_FIRST_EN): fills start at the
// word addressed by req_addr[3:2] and wrap; the first returned word is also
// presented on crit_data with a one-cycle crit_valid pulse.
//
// Ports:
//   clk, RESET     : clock, asynchronous active-high reset
//   req_valid/req_ready, req_rw (1 = writeback), req_addr, req_wdata
//                  : line request from the cache
//   resp_valid, resp_data : completion pulse and assembled fill line
//   ram_valid/ram_ready, ram_we, ram_addr, ram_wdata : RAM word request
//   ram_rvalid, ram_rdata : RAM read return
//   crit_valid, crit_data : critical word (only with the macro defined)
// -----------------------------------------------------------------------------
module dcache_line_adapter #(
  parameter int WORD_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                                 clk,
  input  logic                                 RESET,
  input  logic                                 req_valid,
  input  logic                                 req_rw,
  input  logic [ADDR_WIDTH-1:0]                req_addr,
  input  logic [WORD_WIDTH*WORDS_PER_LINE-1:0] req_wdata,
  output logic                                 req_ready,
  output logic                                 resp_valid,
  output logic [WORD_WIDTH*WORDS_PER_LINE-1:0] resp_data,
  output logic                                 ram_valid,
  output logic                                 ram_we,
  output logic [ADDR_WIDTH-1:0]                ram_addr,
  output logic [WORD_WIDTH-1:0]                ram_wdata,
  input  logic                                 ram_ready,
  input  logic                                 ram_rvalid,
  input  logic [WORD_WIDTH-1:0]                ram_rdata
`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
  ,
  output logic                                 crit_valid,
  output logic [WORD_WIDTH-1:0]                crit_data
`endif
);

  import cache_def::*;

  localparam int IDX_W  = $clog2(WORDS_PER_LINE);
  localparam int BEAT_W = $clog2(WORDS_PER_LINE + 1);

  line_adapter_state_type state_q, state_d;

  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      cnt_inc;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  last_beat;

  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  cache_data_type        resp_data_q, resp_data_d;
  logic                  ram_valid_q, ram_valid_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [WORD_WIDTH-1:0] ram_wdata_q, ram_wdata_d;

  logic [IDX_W-1:0]      start_idx;

  logic                  buf_load;
  logic                  buf_wr_en;
  logic [WORD_WIDTH-1:0] buf_rd_data;
  cache_data_type        buf_line;
  cache_data_type        fill_line;

`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
  logic                  crit_valid_q, crit_valid_d;
  logic [WORD_WIDTH-1:0] crit_data_q, crit_data_d;
`endif

  // Low address bits only select the starting word (with the macro) and are
  // otherwise meaningless for a line-aligned transfer.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[LINE_OFFSET_BITS-1:0];

  function automatic logic [ADDR_WIDTH-1:0] word_addr(
    input logic [ADDR_WIDTH-1:0] base,
    input logic [IDX_W-1:0]      idx
  );
    logic [ADDR_WIDTH-1:0] off;
    off            = '0;
    off[IDX_W+1:2] = idx;
    return base | off;
  endfunction

`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
  assign start_idx = IDX_W'(req_addr[LINE_OFFSET_BITS-1:2]);
`else
  assign start_idx = '0;
`endif

  assign cnt_inc   = cnt_q + 1'b1;
  assign last_beat = (beat_q == BEAT_W'(WORDS_PER_LINE - 1));

  line_word_buffer #(
    .WORD_WIDTH (WORD_WIDTH),
    .WORDS      (WORDS_PER_LINE)
  ) u_buf (
    .clk         (clk),
    .load_i      (buf_load),
    .load_line_i (req_wdata),
    .wr_en_i     (buf_wr_en),
    .wr_idx_i    (cnt_q),
    .wr_data_i   (ram_rdata),
    .rd_idx_i    (cnt_inc),
    .rd_data_o   (buf_rd_data),
    .line_o      (buf_line)
  );

  // The final fill word is written into the buffer on the same edge that
  // registers the response, so merge it in directly.
  always_comb begin
    fill_line = buf_line;
    fill_line[cnt_q*WORD_WIDTH +: WORD_WIDTH] = ram_rdata;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    beat_d       = beat_q;
    base_d       = base_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    ram_valid_d  = ram_valid_q;
    ram_we_d     = ram_we_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    buf_load     = 1'b0;
    buf_wr_en    = 1'b0;
`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
    crit_valid_d = 1'b0;
    crit_data_d  = crit_data_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          base_d      = {req_addr[ADDR_WIDTH-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
          beat_d      = '0;
          req_ready_d = 1'b0;
          ram_valid_d = 1'b1;
          if (req_rw) begin
            // Writebacks always start at word 0, whatever the address offset.
            state_d     = WR_REQ;
            cnt_d       = '0;
            ram_we_d    = 1'b1;
            ram_addr_d  = word_addr(base_d, '0);
            ram_wdata_d = req_wdata[WORD_WIDTH-1:0];
            buf_load    = 1'b1;
          end else begin
            state_d    = RD_REQ;
            cnt_d      = start_idx;
            ram_we_d   = 1'b0;
            ram_addr_d = word_addr(base_d, start_idx);
          end
        end
      end

      RD_REQ: begin
        if (ram_ready) begin
          state_d     = RD_WAIT;
          ram_valid_d = 1'b0;
        end
      end

      RD_WAIT: begin
        if (ram_rvalid) begin
          buf_wr_en = 1'b1;
          beat_d    = beat_q + 1'b1;
`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
          if (beat_q == '0) begin
            crit_valid_d = 1'b1;
            crit_data_d  = ram_rdata;
          end
`endif
          if (last_beat) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_data_d  = fill_line;
          end else begin
            // cnt is allowed to wrap here: with a non-zero start word the
            // sequence runs e.g. 2, 3, 0, 1.
            state_d     = RD_REQ;
            cnt_d       = cnt_inc;
            ram_valid_d = 1'b1;
            ram_addr_d  = word_addr(base_q, cnt_inc);
          end
        end
      end

      WR_REQ: begin
        if (ram_ready) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            ram_valid_d  = 1'b0;
            ram_we_d     = 1'b0;
          end else begin
            cnt_d       = cnt_inc;
            ram_addr_d  = word_addr(base_q, cnt_inc);
            ram_wdata_d = buf_rd_data;
          end
        end
      end

      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end

      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        ram_valid_d = 1'b0;
        ram_we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      beat_q       <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      ram_valid_q  <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
      crit_valid_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      beat_q       <= beat_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      ram_valid_q  <= ram_valid_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
      crit_valid_q <= crit_valid_d;
`endif
    end
  end

  // Line base (and the critical word) are only meaningful while qualified by
  // control state, so they carry no reset.
  always_ff @(posedge clk) begin
    base_q <= base_d;
`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
    crit_data_q <= crit_data_d;
`endif
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign ram_valid  = ram_valid_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
  assign crit_valid = crit_valid_q;
  assign crit_data  = crit_data_q;
`endif

endmodule

// File: tb/tb_dcache_line_adapter.sv
// -----------------------------------------------------------------------------
// tb_dcache_line_adapter
// Directed and randomized line transfers against a word-addressed memory
// model; expected lines, address orders and latencies are derived from the
// memory contents and the transfer rules.
// -----------------------------------------------------------------------------
module tb_dcache_line_adapter;

  logic         clk = 1'b0;
  logic         RESET = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_rw = 1'b0;
  logic [31:0]  req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic         req_ready;
  logic         resp_valid;
  logic [127:0] resp_data;
  logic         ram_valid;
  logic         ram_we;
  logic [31:0]  ram_addr;
  logic [31:0]  ram_wdata;
  logic         ram_ready = 1'b0;
  logic         ram_rvalid = 1'b0;
  logic [31:0]  ram_rdata = '0;
`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
  logic         crit_valid;
  logic [31:0]  crit_data;
`endif

  dcache_line_adapter dut (
    .clk        (clk),
    .RESET      (RESET),
    .req_valid  (req_valid),
    .req_rw     (req_rw),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .ram_valid  (ram_valid),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_ready  (ram_ready),
    .ram_rvalid (ram_rvalid),
    .ram_rdata  (ram_rdata)
`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
    ,
    .crit_valid (crit_valid),
    .crit_data  (crit_data)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  // Last fill line the adapter should be presenting on resp_data.
  logic [127:0] exp_resp = '0;

  // Word-addressed memory behind the RAM port.
  logic [31:0] mem [bit [31:0]];

  function automatic logic [31:0] mrd(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"},  req_ready,  1'b1);
    chk({tag, "_resp_valid"}, resp_valid, 1'b0);
    chk({tag, "_resp_data"},  resp_data,  128'h0);
    chk({tag, "_ram_valid"},  ram_valid,  1'b0);
    chk({tag, "_ram_we"},     ram_we,     1'b0);
    chk({tag, "_ram_addr"},   ram_addr,   32'h0);
    chk({tag, "_ram_wdata"},  ram_wdata,  32'h0);
  endtask

  // Called at a negedge where the adapter should be requesting word address a.
  // Returns at the negedge after the word has been delivered.
  task automatic rd_word(input logic [31:0] a, input int stall, input int lat);
    logic [31:0] d;
    d = mrd(a);
    chk("rd_valid", ram_valid, 1'b1);
    chk("rd_we",    ram_we,    1'b0);
    chk("rd_addr",  ram_addr,  a);
    chk("rd_busy",  req_ready, 1'b0);
    for (int s = 0; s < stall; s++) begin
      ram_ready = 1'b0;
      step();
      chk("rd_hold_valid", ram_valid, 1'b1);
      chk("rd_hold_addr",  ram_addr,  a);
    end
    ram_ready = 1'b1;
    step();
    ram_ready = 1'($urandom_range(0, 1));
    chk("rd_wait_idle", ram_valid, 1'b0);
    for (int l = 0; l < lat; l++) begin
      step();
      chk("rd_wait_idle", ram_valid, 1'b0);
    end
    ram_rvalid = 1'b1;
    ram_rdata  = d;
    step();
    ram_rvalid = 1'b0;
    ram_rdata  = $urandom;
    ram_ready  = 1'b0;
  endtask

  // Full fill starting at an IDLE negedge. The nxt_* values are driven on the
  // request port once this fill has been accepted.
  task automatic do_fill(input logic [31:0] addr, input bit zw,
                         input bit nxt_v, input logic nxt_rw,
                         input logic [31:0] nxt_a, input logic [127:0] nxt_d);
    logic [31:0]  base;
    logic [127:0] line;
    int start, t0, w, st, lt, extra;
    base = {addr[31:4], 4'h0};
    for (int i = 0; i < 4; i++) line[32*i +: 32] = mrd(base + 32'(4*i));
    start = 0;
`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
    start = int'(addr[3:2]);
`endif
    extra = 0;
    chk("fill_idle_ready", req_ready, 1'b1);
    req_valid = 1'b1;
    req_rw    = 1'b0;
    req_addr  = addr;
    req_wdata = {$urandom, $urandom, $urandom, $urandom};
    t0 = cyc;
    step();
    req_valid = nxt_v;
    req_rw    = nxt_rw;
    req_addr  = nxt_a;
    req_wdata = nxt_d;
    for (int k = 0; k < 4; k++) begin
      w  = (start + k) % 4;
      st = zw ? 0 : int'($urandom_range(0, 2));
      lt = zw ? 0 : int'($urandom_range(0, 3));
      extra += st + lt;
      chk("fill_no_resp", resp_valid, 1'b0);
      rd_word(base + 32'(4*w), st, lt);
`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
      chk("crit_valid", crit_valid, 1'(k == 0));
      if (k == 0) chk("crit_data", crit_data, line[32*w +: 32]);
`endif
    end
    chk("fill_resp_valid", resp_valid, 1'b1);
    chk("fill_resp_data",  resp_data,  line);
    chk("fill_ram_quiet",  ram_valid,  1'b0);
    chk("fill_latency",    cyc - t0,   9 + extra);
    exp_resp = line;
    step();
    chk("fill_resp_pulse", resp_valid, 1'b0);
    chk("fill_ram_quiet2", ram_valid,  1'b0);
  endtask

  // Full writeback starting at an IDLE negedge. Word stall_word is held off
  // for stall_n cycles; spur drives random ram_rvalid noise throughout.
  task automatic do_wb(input logic [31:0] addr, input logic [127:0] data, input bit zw,
                       input int stall_word, input int stall_n, input bit spur);
    logic [31:0] base, a, wd;
    int t0, ns, extra;
    base  = {addr[31:4], 4'h0};
    extra = 0;
    chk("wb_idle_ready", req_ready, 1'b1);
    req_valid = 1'b1;
    req_rw    = 1'b1;
    req_addr  = addr;
    req_wdata = data;
    t0 = cyc;
    step();
    req_valid = 1'b0;
    req_rw    = 1'($urandom_range(0, 1));
    req_addr  = $urandom;
    req_wdata = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 4; k++) begin
      a  = base + 32'(4*k);
      wd = data[32*k +: 32];
      chk("wb_valid", ram_valid,  1'b1);
      chk("wb_we",    ram_we,     1'b1);
      chk("wb_addr",  ram_addr,   a);
      chk("wb_wdata", ram_wdata,  wd);
      chk("wb_busy",  req_ready,  1'b0);
      chk("wb_no_resp", resp_valid, 1'b0);
      ns = (k == stall_word) ? stall_n : (zw ? 0 : int'($urandom_range(0, 2)));
      extra += ns;
      for (int s = 0; s < ns; s++) begin
        ram_ready = 1'b0;
        if (spur) begin
          ram_rvalid = 1'($urandom_range(0, 1));
          ram_rdata  = $urandom;
        end
        step();
        chk("wb_hold_valid", ram_valid, 1'b1);
        chk("wb_hold_addr",  ram_addr,  a);
        chk("wb_hold_wdata", ram_wdata, wd);
        chk("wb_hold_busy",  req_ready, 1'b0);
      end
      ram_ready = 1'b1;
      if (spur) begin
        ram_rvalid = 1'($urandom_range(0, 1));
        ram_rdata  = $urandom;
      end
      step();
      ram_ready  = 1'b0;
      ram_rvalid = 1'b0;
      mem[a] = wd;
    end
    chk("wb_resp_valid", resp_valid, 1'b1);
    chk("wb_resp_data",  resp_data,  exp_resp);
    chk("wb_ram_quiet",  ram_valid,  1'b0);
    chk("wb_latency",    cyc - t0,   5 + extra);
    step();
    chk("wb_resp_pulse", resp_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;

    // Reset behaviour
    #2 RESET = 1'b1;
    #1 chk_reset_outputs("reset");
    step();
    step();
    RESET = 1'b0;
    step();
    chk_reset_outputs("post_reset");

    // Directed fill with zero-wait RAM
    mem[32'h0000_1230] = 32'h1111_1111;
    mem[32'h0000_1234] = 32'h2222_2222;
    mem[32'h0000_1238] = 32'h3333_3333;
    mem[32'h0000_123C] = 32'h4444_4444;
    do_fill(32'h0000_1230, 1'b1, 1'b0, 1'b0, 32'h0, 128'h0);
    chk("fill_directed_line", exp_resp, 128'h4444_4444_3333_3333_2222_2222_1111_1111);

    // Writeback with word 1 stalled for 3 cycles
    do_wb(32'h0000_4000, 128'h0000_DDDD_0000_CCCC_0000_BBBB_0000_AAAA, 1'b1, 1, 3, 1'b0);
    chk("wb_mem_word3", mem[32'h0000_400C], 32'h0000_DDDD);

    // Zero-wait writeback with spurious ram_rvalid during WR_REQ
    do_wb(32'h0000_5000, {$urandom, $urandom, $urandom, $urandom}, 1'b1, -1, 0, 1'b1);

    // Spurious ram_rvalid in IDLE
    ram_rvalid = 1'b1;
    ram_rdata  = 32'hBAD0_BAD0;
    step();
    ram_rvalid = 1'b0;
    chk("idle_spur_ready",  req_ready,  1'b1);
    chk("idle_spur_valid",  ram_valid,  1'b0);
    chk("idle_spur_resp",   resp_valid, 1'b0);
    chk("idle_spur_data",   resp_data,  exp_resp);

    // Back-to-back: fill with the following writeback request held on the port
    do_fill(32'h0000_4000, 1'b1, 1'b1, 1'b1, 32'h0000_7000,
            128'h7777_0003_7777_0002_7777_0001_7777_0000);
    chk("b2b_still_requesting", req_valid, 1'b1);
    do_wb(32'h0000_7000, 128'h7777_0003_7777_0002_7777_0001_7777_0000, 1'b1, -1, 0, 1'b0);

    // Reset in the middle of a fill, after two words
    chk("mid_idle_ready", req_ready, 1'b1);
    req_valid = 1'b1;
    req_rw    = 1'b0;
    req_addr  = 32'h0000_6000;
    step();
    req_valid = 1'b0;
    rd_word(32'h0000_6000, 0, 0);
    rd_word(32'h0000_6004, 0, 1);
    RESET = 1'b1;
    #1 chk_reset_outputs("mid_reset");
    step();
    RESET = 1'b0;
    ram_rvalid = 1'b1;
    ram_rdata  = 32'hDEAD_BEEF;
    step();
    ram_rvalid = 1'b0;
    chk("late_rvalid_resp",  resp_valid, 1'b0);
    chk_reset_outputs("late_rvalid");
    exp_resp = '0;
    do_fill(32'h0000_6000, 1'b1, 1'b0, 1'b0, 32'h0, 128'h0);

`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
    // Critical-word-first fill starting at word 2
    mem[32'h0000_2000] = 32'hA0A0_0000;
    mem[32'h0000_2004] = 32'hA1A1_1111;
    mem[32'h0000_2008] = 32'hA2A2_2222;
    mem[32'h0000_200C] = 32'hA3A3_3333;
    do_fill(32'h0000_2008, 1'b1, 1'b0, 1'b0, 32'h0, 128'h0);
    chk("cwf_line", resp_data, 128'hA3A3_3333_A2A2_2222_A1A1_1111_A0A0_0000);
`endif

    // Randomized mix over a small set of lines so fills see earlier writebacks
    for (int it = 0; it < 24; it++) begin
      ra = 32'h0000_8000 + (32'($urandom_range(0, 3)) << 4) + 32'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        do_wb(ra, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1);
      end else begin
        do_fill(ra, 1'($urandom_range(0, 1)), 1'b0, 1'b0, $urandom, 128'h0);
      end
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        step();
        chk("gap_idle", req_ready, 1'b1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
